// File: rtl/line_track_fsm.sv
// Line-follower mode controller: synchronises and debounces three IR tracker inputs,
// then steers a STOP/RUNNING/TURN_LEFT/TURN_RIGHT[/SEARCH] FSM. SEARCH is built only with TRACK_LOST_SEARCH_EN.
module line_track_fsm #(
    parameter int unsigned FILT_CYC     = 50000,
    parameter int unsigned MIN_HOLD     = 100000,
    parameter int unsigned LOST_TIMEOUT = 50000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       left_signal,
    input  logic       mid_signal,
    input  logic       right_signal,
    output logic [1:0] state,
    output logic       lost,
    output logic       halted,
    output logic [2:0] filt
);

    localparam logic [1:0]  ST_STOP   = 2'd0;
    localparam logic [1:0]  ST_LEFT   = 2'd1;
    localparam logic [1:0]  ST_RIGHT  = 2'd2;
    localparam logic [1:0]  ST_RUN    = 2'd3;
    localparam logic [19:0] FILT_LAST = 20'(FILT_CYC - 1);
    localparam logic [26:0] HOLD_MAX  = 27'(MIN_HOLD);

    typedef enum logic [2:0] {
        S_STOP,
        S_RUNNING,
        S_TURN_LEFT,
        S_TURN_RIGHT,
        S_SEARCH
    } fsm_t;

    typedef enum logic [2:0] {
        D_RUN,
        D_LEFT,
        D_RIGHT,
        D_KEEP,
        D_LOST
    } dec_t;

`ifdef TRACK_LOST_SEARCH_EN
    localparam fsm_t        LOST_DEST = S_SEARCH;
    localparam logic [26:0] LOST_LAST = 27'(LOST_TIMEOUT - 1);
    logic [26:0] r_lost_cnt;
`else
    localparam fsm_t        LOST_DEST = S_STOP;
`endif

    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [2:0]  r_cand;
    logic [19:0] r_stab;

    fsm_t        r_fsm;
    logic [26:0] r_hold;
    logic        r_last_left;

    fsm_t        w_next;
    dec_t        w_dec;
    logic        w_hold_ok;
    logic        w_last_left;

    // r_cand is the previous synchronised sample; a mismatch restarts the stability count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
            r_cand  <= 3'b000;
            r_stab  <= 20'd0;
            filt    <= 3'b000;
        end else begin
            r_sync1 <= {left_signal, mid_signal, right_signal};
            r_sync2 <= r_sync1;
            r_cand  <= r_sync2;
            if (r_sync2 != r_cand) begin
                r_stab <= 20'd0;
            end else if (r_stab == FILT_LAST) begin
                filt <= r_sync2;
            end else begin
                r_stab <= r_stab + 20'd1;
            end
        end
    end

    always_comb begin
        w_dec = D_KEEP;
        case (filt)
            3'b010, 3'b111: w_dec = D_RUN;
            3'b100, 3'b110: w_dec = D_LEFT;
            3'b001, 3'b011: w_dec = D_RIGHT;
            3'b000:         w_dec = D_LOST;
            default:        w_dec = D_KEEP;
        endcase
    end

    assign w_hold_ok = (r_hold >= HOLD_MAX);

    always_comb begin
        w_next = r_fsm;
        case (r_fsm)
            S_STOP: begin
                if (w_dec == D_RUN) w_next = S_RUNNING;
            end
            S_RUNNING: begin
                case (w_dec)
                    D_LEFT:  w_next = S_TURN_LEFT;
                    D_RIGHT: w_next = S_TURN_RIGHT;
                    D_LOST:  w_next = LOST_DEST;
                    default: w_next = S_RUNNING;
                endcase
            end
            // Losing the line overrides the minimum turn hold.
            S_TURN_LEFT, S_TURN_RIGHT: begin
                if (w_dec == D_LOST) begin
                    w_next = LOST_DEST;
                end else if (w_hold_ok) begin
                    case (w_dec)
                        D_RUN:   w_next = S_RUNNING;
                        D_LEFT:  w_next = S_TURN_LEFT;
                        D_RIGHT: w_next = S_TURN_RIGHT;
                        default: w_next = r_fsm;
                    endcase
                end
            end
`ifdef TRACK_LOST_SEARCH_EN
            S_SEARCH: begin
                case (w_dec)
                    D_LOST:  w_next = (r_lost_cnt == LOST_LAST) ? S_STOP : S_SEARCH;
                    D_LEFT:  w_next = S_TURN_LEFT;
                    D_RIGHT: w_next = S_TURN_RIGHT;
                    default: w_next = S_RUNNING;
                endcase
            end
`endif
            default: w_next = S_STOP;
        endcase
    end

    always_comb begin
        w_last_left = r_last_left;
        if (w_next == S_TURN_LEFT) begin
            w_last_left = 1'b1;
        end else if (w_next == S_TURN_RIGHT) begin
            w_last_left = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= S_STOP;
            r_hold      <= 27'd0;
            r_last_left <= 1'b1;
`ifdef TRACK_LOST_SEARCH_EN
            r_lost_cnt  <= 27'd0;
`endif
            state       <= ST_STOP;
            lost        <= 1'b0;
            halted      <= 1'b1;
        end else begin
            r_fsm       <= w_next;
            r_last_left <= w_last_left;
            if (w_next != r_fsm) begin
                r_hold <= 27'd0;
            end else if (r_hold < HOLD_MAX) begin
                r_hold <= r_hold + 27'd1;
            end
`ifdef TRACK_LOST_SEARCH_EN
            // Counts only while SEARCH persists, so it restarts on both entry and exit.
            if (r_fsm == S_SEARCH && w_next == S_SEARCH) begin
                r_lost_cnt <= r_lost_cnt + 27'd1;
            end else begin
                r_lost_cnt <= 27'd0;
            end
`endif
            case (w_next)
                S_RUNNING: begin
                    state  <= ST_RUN;
                    lost   <= 1'b0;
                    halted <= 1'b0;
                end
                S_TURN_LEFT: begin
                    state  <= ST_LEFT;
                    lost   <= 1'b0;
                    halted <= 1'b0;
                end
                S_TURN_RIGHT: begin
                    state  <= ST_RIGHT;
                    lost   <= 1'b0;
                    halted <= 1'b0;
                end
`ifdef TRACK_LOST_SEARCH_EN
                S_SEARCH: begin
                    state  <= w_last_left ? ST_LEFT : ST_RIGHT;
                    lost   <= 1'b1;
                    halted <= 1'b0;
                end
`endif
                default: begin
                    state  <= ST_STOP;
                    lost   <= 1'b0;
                    halted <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/line_track_fsm.md
LINE_TRACK_FSM -- requirements
Module: line_track_fsm

Interface
REQ-001 The block SHALL have parameter FILT_CYC, default 50000, meaning cycles a sensor pattern must stay stable before it is accepted (1..2^20-1).
REQ-002 The block SHALL have parameter MIN_HOLD, default 100000, meaning minimum cycles spent in TURN_LEFT/TURN_RIGHT before a decoded change is taken (1..2^27-1).
REQ-003 The block SHALL have parameter LOST_TIMEOUT, default 50000000, meaning SEARCH cycles before giving up to STOP (1..2^27-1).
REQ-004 The block SHALL have port clk, input, 1 bit: system clock; the single clock for all logic.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports left_signal, mid_signal, right_signal, each input, 1 bit: raw asynchronous IR tracker inputs, 1 = line seen.
REQ-007 The block SHALL have port state, output, 2 bits: motor mode consumed by the motor/steering stage; STOP=0, TURN_LEFT=1, TURN_RIGHT=2, RUNNING=3.
REQ-008 The block SHALL have port lost, output, 1 bit: 1 while in SEARCH.
REQ-009 The block SHALL have port halted, output, 1 bit: 1 while in STOP.
REQ-010 The block SHALL have port filt, output, 3 bits: accepted pattern {left,mid,right}.

Function
REQ-011 Each raw input SHALL pass a 2-FF synchronizer before any other use.
REQ-012 Filter: candidate = synchronized {l,m,r}; stable counter SHALL clear on any candidate change and increment otherwise; when it reaches FILT_CYC-1 with the candidate unchanged, filt SHALL load candidate; a constant raw change appears on filt exactly FILT_CYC+3 cycles later.
REQ-013 Decode of filt: 010 or 111 -> RUNNING; 100 or 110 -> TURN_LEFT; 001 or 011 -> TURN_RIGHT; 101 -> no change (keep current state); 000 -> LOST.
REQ-014 FSM states SHALL be STOP, RUNNING, TURN_LEFT, TURN_RIGHT, SEARCH; state output SHALL register one cycle after filt changes.
REQ-015 From RUNNING, any decoded change SHALL be taken immediately.
REQ-016 From TURN_LEFT/TURN_RIGHT, a decoded change SHALL be taken only when hold counter >= MIN_HOLD; otherwise the current state is held and the request re-evaluated each cycle.
REQ-017 Hold counter SHALL clear on every state change, increment each cycle, and saturate at MIN_HOLD.
REQ-018 last_dir SHALL update to LEFT/RIGHT on each entry to TURN_LEFT/TURN_RIGHT; reset value LEFT.
REQ-019 LOST from RUNNING/TURN_* SHALL enter SEARCH, ignoring hold; SEARCH drives state = TURN_LEFT if last_dir=LEFT, else TURN_RIGHT.
REQ-020 In SEARCH, any non-LOST decode SHALL exit immediately to the decoded state (101 -> RUNNING); lost counter clears on entry and on exit.
REQ-021 Lost counter reaching LOST_TIMEOUT-1 while still LOST SHALL enter STOP; exit and timeout in the same cycle -> exit wins.
REQ-022 STOP SHALL be left only on decode RUNNING (010/111) -> RUNNING; all other patterns keep STOP.
REQ-023 Counters SHALL be 27 bits wide (filter 20 bits) and never wrap; all outputs are registered.

Reset
REQ-024 rst_n low SHALL asynchronously set: state=STOP (0), halted=1, lost=0, filt=000, synchronizers=0, all counters=0, last_dir=LEFT.
REQ-025 Reset asserted mid-SEARCH or mid-hold SHALL abort immediately; no counter value survives.

Configuration
REQ-026 Macro TRACK_LOST_SEARCH_EN defined: SEARCH behaviour per REQ-019..021.
REQ-027 Macro TRACK_LOST_SEARCH_EN undefined: SEARCH and the lost counter are not built; LOST from any state enters STOP next cycle; lost is tied to 0.

Verification (FILT_CYC=4, MIN_HOLD=8, LOST_TIMEOUT=20)
REQ-028 The bench SHALL cover: reset release, raw 010 held -> filt=010 at cycle 7, state=3 at cycle 8, halted=0.
REQ-029 The bench SHALL cover: in RUNNING, 100 glitch of 3 cycles -> filt and state unchanged; 100 held -> state=1.
REQ-030 The bench SHALL cover: entering TURN_LEFT, then 010 accepted 2 cycles later -> state stays 1 until hold=8, then state=3.
REQ-031 The bench SHALL cover (macro on): from TURN_RIGHT, 000 held -> lost=1, state=2, 20 cycles later state=0, halted=1; a repeat run with 001 restored at SEARCH cycle 10 -> state=2, lost=0.
REQ-032 The bench SHALL cover (macro off): from RUNNING, 000 accepted -> state=0 next cycle, lost=0.
REQ-033 The bench SHALL cover: rst_n pulsed low mid-SEARCH -> state=0 and filt=000 asynchronously, before the next clk edge.
